// File: rtl/tl_ul_pkg.sv
// Shared TileLink UL definitions for the slave memory endpoint.
// Holds the A/D channel opcode constants, the default channel widths and
// the state encoding of the slave request/response sequencer.
package tl_ul_pkg;

    // Default channel widths
    localparam int TL_ADDR_WIDTH_DEF   = 64;
    localparam int TL_DATA_WIDTH_DEF   = 64;
    localparam int TL_STRB_WIDTH_DEF   = TL_DATA_WIDTH_DEF / 8;
    localparam int TL_SOURCE_WIDTH_DEF = 3;
    localparam int TL_SINK_WIDTH_DEF   = 3;
    localparam int TL_OPCODE_WIDTH_DEF = 3;
    localparam int TL_PARAM_WIDTH_DEF  = 3;
    localparam int TL_SIZE_WIDTH_DEF   = 8;

    // Channel A opcodes
    localparam logic [2:0] PUT_FULL_DATA_A    = 3'd0;
    localparam logic [2:0] PUT_PARTIAL_DATA_A = 3'd1;
    localparam logic [2:0] ARITHMETIC_DATA_A  = 3'd2;
    localparam logic [2:0] LOGICAL_DATA_A     = 3'd3;
    localparam logic [2:0] GET_A              = 3'd4;
    localparam logic [2:0] INTENT_A           = 3'd5;

    // Channel D opcodes
    localparam logic [2:0] ACCESS_ACK_D       = 3'd0;
    localparam logic [2:0] ACCESS_ACK_DATA_D  = 3'd1;

    // Slave sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } slave_state_e;

endpackage

// File: rtl/tilelink_ul_slave_mem_if.sv
// TileLink UL A/D channel pair.
// master modport: drives channel A, receives channel D.
// slave modport : receives channel A, drives channel D.
interface tilelink_ul_slave_mem_if #(
    parameter int TL_ADDR_WIDTH   = tl_ul_pkg::TL_ADDR_WIDTH_DEF,
    parameter int TL_DATA_WIDTH   = tl_ul_pkg::TL_DATA_WIDTH_DEF,
    parameter int TL_STRB_WIDTH   = TL_DATA_WIDTH / 8,
    parameter int TL_SOURCE_WIDTH = tl_ul_pkg::TL_SOURCE_WIDTH_DEF,
    parameter int TL_SINK_WIDTH   = tl_ul_pkg::TL_SINK_WIDTH_DEF,
    parameter int TL_OPCODE_WIDTH = tl_ul_pkg::TL_OPCODE_WIDTH_DEF,
    parameter int TL_PARAM_WIDTH  = tl_ul_pkg::TL_PARAM_WIDTH_DEF,
    parameter int TL_SIZE_WIDTH   = tl_ul_pkg::TL_SIZE_WIDTH_DEF
) ();

    // Channel A
    logic                       a_valid;
    logic                       a_ready;
    logic [TL_OPCODE_WIDTH-1:0] a_opcode;
    logic [TL_PARAM_WIDTH-1:0]  a_param;
    logic [TL_ADDR_WIDTH-1:0]   a_address;
    logic [TL_SIZE_WIDTH-1:0]   a_size;
    logic [TL_STRB_WIDTH-1:0]   a_mask;
    logic [TL_DATA_WIDTH-1:0]   a_data;
    logic [TL_SOURCE_WIDTH-1:0] a_source;

    // Channel D
    logic                       d_valid;
    logic                       d_ready;
    logic [TL_OPCODE_WIDTH-1:0] d_opcode;
    logic [TL_PARAM_WIDTH-1:0]  d_param;
    logic [TL_SIZE_WIDTH-1:0]   d_size;
    logic [TL_SINK_WIDTH-1:0]   d_sink;
    logic [TL_SOURCE_WIDTH-1:0] d_source;
    logic [TL_DATA_WIDTH-1:0]   d_data;
    logic                       d_error;

    modport master (
        output a_valid, a_opcode, a_param, a_address, a_size, a_mask, a_data, a_source,
        input  a_ready,
        input  d_valid, d_opcode, d_param, d_size, d_sink, d_source, d_data, d_error,
        output d_ready
    );

    modport slave (
        input  a_valid, a_opcode, a_param, a_address, a_size, a_mask, a_data, a_source,
        output a_ready,
        output d_valid, d_opcode, d_param, d_size, d_sink, d_source, d_data, d_error,
        input  d_ready
    );

endinterface

// File: rtl/tl_ul_slave_regfile.sv
// Byte-maskable word memory for the TileLink UL slave.
// Ports:
//   clk, rst        clock, asynchronous active-high clear of every word
//   we, widx        write enable and word index
//   wmask, wdata    byte-lane enables and write data
//   ridx, rdata     asynchronous read port
module tl_ul_slave_regfile #(
    parameter int DEPTH      = 16,
    parameter int DATA_WIDTH = 64,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [IDX_W-1:0]      widx,
    input  logic [STRB_WIDTH-1:0] wmask,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [IDX_W-1:0]      ridx,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // NOTE: this is a flop array, so every word is cleared by reset; a
    // macro RAM would have no reset and the clear would need a sweep FSM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            for (int b = 0; b < STRB_WIDTH; b++) begin
                if (wmask[b]) begin
                    mem[widx][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    assign rdata = mem[ridx];

endmodule

// File: rtl/tilelink_ul_slave_mem.sv
// TileLink UL slave endpoint backed by a small byte-maskable word memory.
// Accepts one request at a time on channel A, commits writes at the A-fire
// edge, waits RESP_LATENCY cycles and returns AccessAck/AccessAckData on
// channel D, holding the response stable under backpressure.
// Ports:
//   clk  clock
//   rst  asynchronous active-high reset (clears memory, drops pending response)
//   tl   TileLink UL A/D channel pair, slave side
module tilelink_ul_slave_mem
    import tl_ul_pkg::*;
#(
    parameter int TL_ADDR_WIDTH   = 64,
    parameter int TL_DATA_WIDTH   = 64,
    parameter int TL_STRB_WIDTH   = TL_DATA_WIDTH / 8,
    parameter int TL_SOURCE_WIDTH = 3,
    parameter int TL_SINK_WIDTH   = 3,
    parameter int TL_OPCODE_WIDTH = 3,
    parameter int TL_PARAM_WIDTH  = 3,
    parameter int TL_SIZE_WIDTH   = 8,
    parameter int MEM_DEPTH       = 16,
    parameter logic [TL_ADDR_WIDTH-1:0] BASE_ADDR = '0,
    parameter int RESP_LATENCY    = 2,
    parameter int SINK_ID         = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    tilelink_ul_slave_mem_if.slave  tl
);

    localparam int LANE_BITS = $clog2(TL_STRB_WIDTH);
    localparam int IDX_W     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int CNT_W     = $clog2(RESP_LATENCY + 2);

    slave_state_e state_q, state_d;
    logic [CNT_W-1:0] cnt_q;

    logic a_fire, d_fire, load_d;

    // Request decode
    logic [TL_ADDR_WIDTH-1:0] offset, word, align_mask;
    logic below_base, out_of_range, size_bad, misaligned, op_known;
    logic is_get, is_put, req_error, mem_we;
    logic [TL_DATA_WIDTH-1:0] rdata;

    // Response fields computed from the live A request
    logic [TL_OPCODE_WIDTH-1:0] req_opcode;
    logic [TL_DATA_WIDTH-1:0]   req_data;

    // Pending response fields latched at A fire
    logic [TL_OPCODE_WIDTH-1:0] p_opcode;
    logic [TL_SIZE_WIDTH-1:0]   p_size;
    logic [TL_SOURCE_WIDTH-1:0] p_source;
    logic [TL_DATA_WIDTH-1:0]   p_data;
    logic                       p_error;

    // D channel registers
    logic                       d_valid_q;
    logic [TL_OPCODE_WIDTH-1:0] d_opcode_q;
    logic [TL_SIZE_WIDTH-1:0]   d_size_q;
    logic [TL_SOURCE_WIDTH-1:0] d_source_q;
    logic [TL_DATA_WIDTH-1:0]   d_data_q;
    logic                       d_error_q;

    // a_ready depends on state only; rst forces it low while asserted.
    assign tl.a_ready = (state_q == ST_IDLE) && !rst;
    assign a_fire     = tl.a_valid && tl.a_ready;
    assign d_fire     = d_valid_q && tl.d_ready;

    assign offset       = tl.a_address - BASE_ADDR;
    assign word         = offset >> LANE_BITS;
    assign below_base   = tl.a_address < BASE_ADDR;
    assign out_of_range = word >= TL_ADDR_WIDTH'(MEM_DEPTH);
    assign size_bad     = tl.a_size > TL_SIZE_WIDTH'(LANE_BITS);
    // Low a_size address bits must be zero; oversize requests are already
    // flagged by size_bad, so a saturated mask there is harmless.
    assign align_mask   = ~({TL_ADDR_WIDTH{1'b1}} << tl.a_size);
    assign misaligned   = |(tl.a_address & align_mask);
    assign is_get       = tl.a_opcode == GET_A;
    assign is_put       = (tl.a_opcode == PUT_FULL_DATA_A) ||
                          (tl.a_opcode == PUT_PARTIAL_DATA_A);
    assign op_known     = is_get || is_put;
    assign req_error    = below_base || out_of_range || size_bad || misaligned || !op_known;
    assign mem_we       = a_fire && is_put && !req_error;

    assign req_opcode = is_get ? ACCESS_ACK_DATA_D : ACCESS_ACK_D;
    assign req_data   = (is_get && !req_error) ? rdata : '0;

    tl_ul_slave_regfile #(
        .DEPTH      (MEM_DEPTH),
        .DATA_WIDTH (TL_DATA_WIDTH),
        .STRB_WIDTH (TL_STRB_WIDTH),
        .IDX_W      (IDX_W)
    ) u_regfile (
        .clk   (clk),
        .rst   (rst),
        .we    (mem_we),
        .widx  (word[IDX_W-1:0]),
        .wmask (tl.a_mask),
        .wdata (tl.a_data),
        .ridx  (word[IDX_W-1:0]),
        .rdata (rdata)
    );

    // NOTE: state_d is defaulted to the current state before the case, so
    // every path assigns it and no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (a_fire) state_d = (RESP_LATENCY == 0) ? ST_RESP : ST_WAIT;
            ST_WAIT: if (cnt_q == CNT_W'(1)) state_d = ST_RESP;
            ST_RESP: if (d_fire) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // D registers load on the edge that enters RESP.
    assign load_d = (state_d == ST_RESP) && (state_q != ST_RESP);

    // NOTE: all state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (a_fire) begin
                cnt_q <= CNT_W'(RESP_LATENCY);
            end else if (state_q == ST_WAIT) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_opcode <= '0;
            p_size   <= '0;
            p_source <= '0;
            p_data   <= '0;
            p_error  <= 1'b0;
        end else if (a_fire) begin
            p_opcode <= req_opcode;
            p_size   <= tl.a_size;
            p_source <= tl.a_source;
            p_data   <= req_data;
            p_error  <= req_error;
        end
    end

    // With zero latency RESP is entered straight from IDLE, so the D
    // registers take the live request fields instead of the pending copy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_valid_q  <= 1'b0;
            d_opcode_q <= '0;
            d_size_q   <= '0;
            d_source_q <= '0;
            d_data_q   <= '0;
            d_error_q  <= 1'b0;
        end else if (load_d) begin
            d_valid_q <= 1'b1;
            if (state_q == ST_IDLE) begin
                d_opcode_q <= req_opcode;
                d_size_q   <= tl.a_size;
                d_source_q <= tl.a_source;
                d_data_q   <= req_data;
                d_error_q  <= req_error;
            end else begin
                d_opcode_q <= p_opcode;
                d_size_q   <= p_size;
                d_source_q <= p_source;
                d_data_q   <= p_data;
                d_error_q  <= p_error;
            end
        end else if (d_fire) begin
            d_valid_q  <= 1'b0;
            d_opcode_q <= '0;
            d_size_q   <= '0;
            d_source_q <= '0;
            d_data_q   <= '0;
            d_error_q  <= 1'b0;
        end
    end

    assign tl.d_valid  = d_valid_q;
    assign tl.d_opcode = d_opcode_q;
    assign tl.d_param  = '0;
    assign tl.d_size   = d_size_q;
    assign tl.d_sink   = TL_SINK_WIDTH'(SINK_ID);
    assign tl.d_source = d_source_q;
    assign tl.d_data   = d_data_q;
    assign tl.d_error  = d_error_q;

endmodule

// File: tb/tb_tilelink_ul_slave_mem.sv
// Scoreboard bench for tilelink_ul_slave_mem: the driver pushes the expected
// response for each request; a monitor compares every D-channel response,
// its latency, its stability under backpressure and idle-zero behaviour.
module tb_tilelink_ul_slave_mem;
    import tl_ul_pkg::*;

    localparam int LAT     = 2;
    localparam int SINK_ID = 0;

    typedef struct {
        logic [2:0]  opcode;
        logic [7:0]  size;
        logic [2:0]  source;
        logic [63:0] data;
        logic        error;
    } exp_t;

    exp_t exp_q[$];

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_mis = 0;
    int   cyc = 0;
    int   fire_cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    tilelink_ul_slave_mem_if tl ();

    tilelink_ul_slave_mem #(
        .RESP_LATENCY (LAT),
        .SINK_ID      (SINK_ID)
    ) dut (
        .clk (clk),
        .rst (rst),
        .tl  (tl)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [84:0] d_bundle();
        return {tl.d_opcode, tl.d_param, tl.d_size, tl.d_sink,
                tl.d_source, tl.d_data, tl.d_error};
    endfunction

    // Monitor: samples on the falling edge, away from the active edge.
    initial begin : monitor
        logic        prev_valid;
        logic        fire_pending;
        logic [84:0] snap;
        exp_t        e;
        prev_valid   = 1'b0;
        fire_pending = 1'b0;
        snap         = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_valid   = 1'b0;
                fire_pending = 1'b0;
            end else begin
                if (fire_pending) begin
                    check("a_ready_after_d_fire", tl.a_ready, 1'b1);
                    fire_pending = 1'b0;
                end
                if (tl.d_valid) begin
                    check("a_ready_low_in_resp", tl.a_ready, 1'b0);
                    if (!prev_valid) begin
                        snap = d_bundle();
                        check("resp_latency", cyc - fire_cyc, LAT);
                    end else begin
                        check("d_hold_stable", d_bundle(), snap);
                    end
                    if (tl.d_ready) begin
                        if (exp_q.size() == 0) begin
                            check("unexpected_response", 1'b1, 1'b0);
                        end else begin
                            e = exp_q.pop_front();
                            check("d_opcode", tl.d_opcode, e.opcode);
                            check("d_param",  tl.d_param,  3'd0);
                            check("d_size",   tl.d_size,   e.size);
                            check("d_sink",   tl.d_sink,   3'(SINK_ID));
                            check("d_source", tl.d_source, e.source);
                            check("d_data",   tl.d_data,   e.data);
                            check("d_error",  tl.d_error,  e.error);
                        end
                        fire_pending = 1'b1;
                    end
                end else begin
                    check("d_idle_zero",
                          {tl.d_opcode, tl.d_param, tl.d_size, tl.d_source, tl.d_data, tl.d_error},
                          '0);
                end
                prev_valid = tl.d_valid;
            end
        end
    end

    task automatic send(input logic [2:0] op, input logic [63:0] addr, input logic [7:0] size,
                        input logic [7:0] mask, input logic [63:0] data, input logic [2:0] src,
                        input logic [2:0] e_op, input logic [63:0] e_data, input logic e_err,
                        input bit push);
        exp_t e;
        int   n;
        if (push) begin
            e.opcode = e_op;
            e.size   = size;
            e.source = src;
            e.data   = e_data;
            e.error  = e_err;
            exp_q.push_back(e);
        end
        @(negedge clk);
        tl.a_opcode  = op;
        tl.a_param   = 3'd5;
        tl.a_address = addr;
        tl.a_size    = size;
        tl.a_mask    = mask;
        tl.a_data    = data;
        tl.a_source  = src;
        tl.a_valid   = 1'b1;
        n = 0;
        while (!tl.a_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!tl.a_ready) begin
            check("a_ready_timeout", 1'b0, 1'b1);
            tl.a_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        fire_cyc   = cyc;
        tl.a_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || tl.d_valid) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("response_timeout", exp_q.size(), 0);
    endtask

    task automatic get(input logic [63:0] addr, input logic [2:0] src,
                       input logic [63:0] e_data, input logic e_err);
        send(GET_A, addr, 8'd3, 8'hFF, 64'h0, src, ACCESS_ACK_DATA_D, e_data, e_err, 1'b1);
        wait_idle();
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin : stimulus
        int n;
        rst          = 1'b1;
        tl.a_valid   = 1'b0;
        tl.a_opcode  = '0;
        tl.a_param   = '0;
        tl.a_address = '0;
        tl.a_size    = '0;
        tl.a_mask    = '0;
        tl.a_data    = '0;
        tl.a_source  = '0;
        tl.d_ready   = 1'b1;
        #1;
        check("reset_a_ready", tl.a_ready, 1'b0);
        check("reset_d_valid", tl.d_valid, 1'b0);
        check("reset_d_sink",  tl.d_sink,  3'(SINK_ID));
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        #1 check("a_ready_after_reset", tl.a_ready, 1'b1);

        // Full write, then read back
        send(PUT_FULL_DATA_A, 64'h8, 8'd3, 8'hFF, 64'h1122334455667788, 3'd2,
             ACCESS_ACK_D, 64'h0, 1'b0, 1'b1);
        wait_idle();
        get(64'h8, 3'd1, 64'h1122334455667788, 1'b0);

        // Partial write of the low four lanes
        send(PUT_PARTIAL_DATA_A, 64'h8, 8'd3, 8'h0F, 64'hAAAAAAAABBBBBBBB, 3'd3,
             ACCESS_ACK_D, 64'h0, 1'b0, 1'b1);
        wait_idle();
        get(64'h8, 3'd4, 64'h11223344BBBBBBBB, 1'b0);

        // Out of range, then word 0 still zero
        get(64'h80, 3'd6, 64'h0, 1'b1);
        get(64'h0,  3'd7, 64'h0, 1'b0);

        // Backpressure: d_ready low for 5 cycles of RESP
        @(posedge clk);
        #1 tl.d_ready = 1'b0;
        send(PUT_FULL_DATA_A, 64'h10, 8'd3, 8'hFF, 64'hCAFEF00D12345678, 3'd5,
             ACCESS_ACK_D, 64'h0, 1'b0, 1'b1);
        n = 0;
        while (!tl.d_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("stall_d_valid_seen", tl.d_valid, 1'b1);
        repeat (5) @(negedge clk);
        @(posedge clk);
        #1 tl.d_ready = 1'b1;
        wait_idle();
        get(64'h10, 3'd0, 64'hCAFEF00D12345678, 1'b0);

        // Unsupported opcode: AccessAck with error, no write
        send(ARITHMETIC_DATA_A, 64'h0, 8'd3, 8'hFF, 64'hFFFFFFFFFFFFFFFF, 3'd1,
             ACCESS_ACK_D, 64'h0, 1'b1, 1'b1);
        wait_idle();
        get(64'h0, 3'd2, 64'h0, 1'b0);

        // Misaligned put: error, no write
        send(PUT_FULL_DATA_A, 64'h2, 8'd2, 8'h0F, 64'h5555555555555555, 3'd3,
             ACCESS_ACK_D, 64'h0, 1'b1, 1'b1);
        wait_idle();
        get(64'h0, 3'd4, 64'h0, 1'b0);

        // Oversize get
        send(GET_A, 64'h0, 8'd4, 8'hFF, 64'h0, 3'd5, ACCESS_ACK_DATA_D, 64'h0, 1'b1, 1'b1);
        wait_idle();

        // Reset while in WAIT: response dropped, memory cleared
        send(GET_A, 64'h8, 8'd3, 8'hFF, 64'h0, 3'd6, ACCESS_ACK_DATA_D, 64'h0, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_d_valid", tl.d_valid, 1'b0);
        check("rst_mid_a_ready", tl.a_ready, 1'b0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        #1 check("a_ready_after_mid_reset", tl.a_ready, 1'b1);
        get(64'h8,  3'd1, 64'h0, 1'b0);
        get(64'h10, 3'd2, 64'h0, 1'b0);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
